// File: rtl/ucdp_clk_div_pkg.sv
// ucdp_clk_div_pkg
//   Shared types for the clock divider: the divider state machine encoding.
package ucdp_clk_div_pkg;

    // IDLE: no period in progress, outputs low.
    // RUN : periods repeat while en_i stays high.
    // STOP: en_i dropped mid-period; the current period is finished first.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/ucdp_clk_buf.sv
// ucdp_clk_buf
//   Clock buffer cell wrapper for a flop-generated clock. Behaviourally a wire;
//   a technology cell is substituted here at implementation.
//   clk_i : clock from the generating flop
//   clk_o : buffered clock
module ucdp_clk_buf (
    input  logic clk_i,
    output logic clk_o
);

    assign clk_o = clk_i;

endmodule

// File: rtl/ucdp_clk_div.sv
// ucdp_clk_div
//   Programmable integer clock divider. Produces a glitch-free divided clock
//   of period N = div+1 input cycles, high for ceil(N/2) and low for floor(N/2).
//   Ratio changes are deferred to the next period boundary; disabling lets the
//   running period complete.
//   clk_i     : sole clock
//   rst_i     : asynchronous, active-high reset
//   en_i      : run request (level)
//   div_i     : divide ratio minus one, sampled when upd_i is high
//   upd_i     : one-cycle request to load div_i
//   upd_ack_o : one-cycle pulse when a loaded ratio takes effect
//   clk_o     : divided clock (flop output through ucdp_clk_buf)
//   stb_o     : one-cycle pulse with each rising edge of clk_o
//   busy_o    : high while a period is in progress
module ucdp_clk_div
    import ucdp_clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             upd_i,
    output logic             upd_ack_o,
    output logic             clk_o,
    output logic             stb_o,
    output logic             busy_o
);

    state_t           state_q;
    state_t           state_n;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_pend_q;
    logic             pend_q;
    logic             clk_q;
    logic             stb_q;
    logic             ack_q;

    logic [WIDTH-1:0] high_thr;
    logic             at_end;
    logic             apply;
    logic             run_n;
    logic             clk_n;
    logic             stb_n;

    always_comb begin
        state_n  = state_q;
        cnt_n    = '0;
        apply    = 1'b0;
        // div/2+1 never exceeds 2^(WIDTH-1), so it fits in WIDTH bits.
        high_thr = (div_q >> 1) + WIDTH'(1);
        at_end   = (cnt_q == div_q);

        case (state_q)
            IDLE: begin
                apply   = pend_q;
                state_n = en_i ? RUN : IDLE;
            end
            RUN, STOP: begin
                if (at_end) begin
                    // Period boundary: the only point where the ratio may change
                    // or the divider may fall idle.
                    apply   = pend_q;
                    state_n = en_i ? RUN : IDLE;
                end else begin
                    cnt_n   = cnt_q + WIDTH'(1);
                    state_n = en_i ? RUN : STOP;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values so they align with cnt_q.
        run_n = (state_n != IDLE);
        clk_n = run_n && (cnt_n < high_thr);
        stb_n = run_n && (cnt_n == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            stb_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            clk_q   <= clk_n;
            stb_q   <= stb_n;
            ack_q   <= apply;
            if (apply) begin
                div_q <= div_pend_q;
            end
            // A request arriving on the boundary cycle is held for the next one.
            if (upd_i) begin
                div_pend_q <= div_i;
                pend_q     <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign upd_ack_o = ack_q;
    assign stb_o     = stb_q;
    assign busy_o    = (state_q != IDLE);

    ucdp_clk_buf u_clk_buf (
        .clk_i (clk_q),
        .clk_o (clk_o)
    );

endmodule

// File: doc/ucdp_clk_div.md
UCDP_CLK_DIV -- requirements
Module: ucdp_clk_div

Interface
REQ-001 Parameter WIDTH, default 8: width of the divide-ratio field.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk_i  input  1: sole clock.
REQ-004 rst_i  input  1: asynchronous, active-high reset.
REQ-005 en_i  input  1: run request; level-sensitive.
REQ-006 div_i  input  WIDTH: divide ratio minus one (N = div_i+1); sampled only on upd_i.
REQ-007 upd_i  input  1: one-cycle request to load div_i.
REQ-008 upd_ack_o  output  1: one-cycle pulse when a loaded ratio takes effect.
REQ-009 clk_o  output  1: divided clock, glitch-free, driven from a flop through a clock buffer.
REQ-010 stb_o  output  1: one-cycle pulse coincident with each rising edge of clk_o.
REQ-011 busy_o  output  1: high while state != IDLE.

Function
REQ-012 State machine with states IDLE, RUN and STOP; state SHALL be registered on clk_i.
REQ-013 Registers SHALL be div_q (active ratio), div_pend_q plus pend_q (pending update), and cnt_q (WIDTH bits, counts 0..div_q and wraps to 0).
REQ-014 High-time threshold H SHALL be div_q/2+1, so clk_o is high for ceil(N/2) cycles and low for floor(N/2) cycles.
REQ-015 clk_o SHALL be registered as (next state in {RUN,STOP}) AND (next cnt < H).
REQ-016 stb_o SHALL be registered as (next state in {RUN,STOP}) AND (next cnt == 0).
REQ-017 IDLE->RUN when en_i=1: on the following cycle cnt_q=0, clk_o=1 and stb_o=1, giving 1-cycle latency.
REQ-018 RUN->STOP when en_i=0 and cnt_q != div_q; RUN->IDLE directly when en_i=0 and cnt_q == div_q.
REQ-019 In STOP the counter SHALL keep running. At cnt_q == div_q: go to IDLE if en_i=0, or continue in RUN with cnt wrapping to 0 if en_i=1.
REQ-020 In STOP with en_i=1 before the period ends: return to RUN with no change to the counter sequence.
REQ-021 In IDLE: cnt_q=0 and clk_o=0.
REQ-022 A period in progress SHALL never be truncated.
REQ-023 When upd_i=1, div_i SHALL be captured into div_pend_q and pend_q set.
REQ-024 A new upd_i while pend_q=1 SHALL overwrite the pending value; only one upd_ack_o results.
REQ-025 Pending ratios SHALL be applied at the next period boundary, i.e. the cycle where cnt wraps to 0. On that cycle div_q<=div_pend_q, pend_q<=0 and upd_ack_o=1.
REQ-026 In IDLE, a pending ratio SHALL be applied on the next cycle.
REQ-027 upd_i on the same cycle as a boundary SHALL be applied at the following boundary, not the current one.
REQ-028 div_q=0 (N=1): clk_o held high and stb_o high every cycle while running; stop takes effect on the next cycle.
REQ-029 Maximum ratio is N = 2^WIDTH (div = all ones); cnt SHALL NOT overflow.

Reset
REQ-030 On rst_i=1, asynchronously: state=IDLE, cnt_q=0, div_q=0, div_pend_q=0, pend_q=0.
REQ-031 On rst_i=1, asynchronously: clk_o=0, stb_o=0, upd_ack_o=0, busy_o=0.
REQ-032 Reset asserted mid-period SHALL force clk_o low immediately; a pending update SHALL be discarded with no ack.
REQ-033 After reset release the block SHALL remain in IDLE until en_i=1.

Structure
REQ-034 Package ucdp_clk_div_pkg SHALL hold the state enum type (IDLE/RUN/STOP).
REQ-035 The clk_o flop output SHALL drive one instance of ucdp_clk_buf; no other sub-modules.

Verification
REQ-036 Set div=2 via upd while idle, en=1 for 9 cycles -> upd_ack next cycle; clk_o pattern 110 repeated; stb_o every 3rd cycle starting cycle 1.
REQ-037 div=3, en runs then drops at cnt=1 -> state STOP; clk_o completes 1100; busy_o falls and clk_o low after cnt=3.
REQ-038 Running div=1, upd div=4 mid-period -> ack exactly at wrap; old period 10 completes, then 11100 repeats; no high/low pulse shorter than 1 cycle.
REQ-039 Two upd (div=5 then div=7) within one period -> single ack; the period after the boundary has length 8.
REQ-040 div=0, en=1 -> clk_o and stb_o constantly high. Assert rst_i mid-run -> all outputs 0 in the same cycle, no upd_ack.
REQ-041 WIDTH=8, div=255 -> period 256 cycles, 128 high, counter wraps cleanly to 0.
